// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_if
//  Purpose  : Request/response/ALU bundle shared by the arbiter and its users.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [3:0]       req0_op;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [3:0]       req1_op;
  logic             rsp0_valid, rsp0_ready, rsp0_zero, rsp0_overflow;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp1_valid, rsp1_ready, rsp1_zero, rsp1_overflow;
  logic [WIDTH-1:0] rsp1_data;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [3:0]       alu_control;
  logic             alu_zero, alu_overflow;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_zero, rsp0_overflow,
    output rsp1_valid, rsp1_data, rsp1_zero, rsp1_overflow,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_control,
    input  alu_out, alu_zero, alu_overflow
  );

  // Requester / ALU side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_zero, rsp0_overflow,
    input  rsp1_valid, rsp1_data, rsp1_zero, rsp1_overflow,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_control,
    output alu_out, alu_zero, alu_overflow
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin sharing of one pipelined ALU between two requesters,
//             returning each tagged result to its owner. ALU_LATENCY 0..4.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic [1:0]       r_busy;
  logic [1:0]       r_rsp_valid;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_rsp_data [2];
  logic [1:0]       r_rsp_zero;
  logic [1:0]       r_rsp_overflow;

  logic [1:0]       w_req_valid;
  logic [1:0]       w_rsp_ready;
  logic [1:0]       w_hs;
  logic [1:0]       w_elig;
  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_exit_v;
  logic             w_exit_id;

  assign w_req_valid = {bus.req1_valid, bus.req0_valid};
  assign w_rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign w_hs        = r_rsp_valid & w_rsp_ready;
  // A result being consumed this cycle frees its owner for a back-to-back issue
  assign w_elig      = w_req_valid & (~r_busy | w_hs);
  assign w_grant[0]  = w_elig[0] & (~w_elig[1] | r_last_grant);
  assign w_grant[1]  = w_elig[1] & (~w_elig[0] | ~r_last_grant);
  assign w_accept    = |w_grant;

  assign bus.req0_ready  = w_grant[0];
  assign bus.req1_ready  = w_grant[1];
  assign bus.alu_a       = w_grant[0] ? bus.req0_a  : (w_grant[1] ? bus.req1_a  : '0);
  assign bus.alu_b       = w_grant[0] ? bus.req0_b  : (w_grant[1] ? bus.req1_b  : '0);
  assign bus.alu_control = w_grant[0] ? bus.req0_op : (w_grant[1] ? bus.req1_op : 4'b0000);

  assign bus.rsp0_valid    = r_rsp_valid[0];
  assign bus.rsp0_data     = r_rsp_data[0];
  assign bus.rsp0_zero     = r_rsp_zero[0];
  assign bus.rsp0_overflow = r_rsp_overflow[0];
  assign bus.rsp1_valid    = r_rsp_valid[1];
  assign bus.rsp1_data     = r_rsp_data[1];
  assign bus.rsp1_zero     = r_rsp_zero[1];
  assign bus.rsp1_overflow = r_rsp_overflow[1];

  generate
    if (ALU_LATENCY == 0) begin : g_no_pipe
      assign w_exit_v  = w_accept;
      assign w_exit_id = w_grant[1];
    end else begin : g_pipe
      // Owner tag travels alongside the op through the ALU stages
      logic [ALU_LATENCY-1:0] r_tag_v;
      logic [ALU_LATENCY-1:0] r_tag_id;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_tag_v  <= '0;
          r_tag_id <= '0;
        end else begin
          r_tag_v[0]  <= w_accept;
          r_tag_id[0] <= w_grant[1];
          for (int i = 1; i < ALU_LATENCY; i++) begin
            r_tag_v[i]  <= r_tag_v[i-1];
            r_tag_id[i] <= r_tag_id[i-1];
          end
        end
      end
      assign w_exit_v  = r_tag_v[ALU_LATENCY-1];
      assign w_exit_id = r_tag_id[ALU_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy         <= '0;
      r_rsp_valid    <= '0;
      r_last_grant   <= 1'b1;
      r_rsp_zero     <= '0;
      r_rsp_overflow <= '0;
      for (int n = 0; n < 2; n++) begin
        r_rsp_data[n] <= '0;
      end
    end else begin
      r_busy <= (r_busy & ~w_hs) | w_grant;
      if (w_accept) begin
        r_last_grant <= w_grant[1];
      end
      for (int n = 0; n < 2; n++) begin
        if (w_exit_v && (w_exit_id == 1'(n))) begin
          r_rsp_valid[n]    <= 1'b1;
          r_rsp_data[n]     <= bus.alu_out;
          r_rsp_zero[n]     <= bus.alu_zero;
          r_rsp_overflow[n] <= bus.alu_overflow;
        end else if (w_hs[n]) begin
          r_rsp_valid[n] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Randomized bench for alu_arbiter at ALU latencies 0, 1 and 3,
//             checked every cycle against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
  localparam int W    = 32;
  localparam int NCYC = 260;
  localparam int RSTC = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Partner ALU behaviour: returns {overflow, zero, result}
  function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      4'b0000: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0001: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b1110: r = a;
      4'b1111: r = 32'hDEAD_BEEF;
      default: r = b;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_cfg
    localparam int LAT = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    logic        rst_n;
    logic [33:0] w_f;
    logic [33:0] r_pipe [4];

    alu_arbiter_if #(.WIDTH(W)) bus ();
    alu_arbiter #(.WIDTH(W), .ALU_LATENCY(LAT)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign w_f = alu_f(bus.alu_a, bus.alu_b, bus.alu_control);
    always @(posedge clk) begin
      r_pipe[0] <= w_f;
      for (int i = 1; i < 4; i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign {bus.alu_overflow, bus.alu_zero, bus.alu_out} =
      (LAT == 0) ? w_f : r_pipe[(LAT == 0) ? 0 : LAT - 1];

    initial begin
      bit          pend [2];
      bit          ob   [2];
      int          ocyc [2];
      logic [33:0] oexp [2];
      logic [W-1:0] ra [2];
      logic [W-1:0] rb [2];
      logic [3:0]  rop [2];
      bit          rdy  [2];
      bit          vexp [2];
      bit          hs   [2];
      bit          el   [2];
      bit          g    [2];
      int          lastg;
      logic [W-1:0] ea, eb;
      logic [3:0]  eop;
      lastg = 1;
      for (int n = 0; n < 2; n++) begin
        ra[n] = '0; rb[n] = '0; rop[n] = '0; oexp[n] = '0;
      end
      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk);
        #1;
        rst_n = !(c < 2 || c == RSTC);
        if (!rst_n) begin
          pend = '{0, 0};
          ob   = '{0, 0};
          lastg = 1;
        end
        for (int n = 0; n < 2; n++) begin
          if (rst_n && !pend[n]) begin
            if (c == 2 && n == 0) begin
              pend[n] = 1; ra[n] = 10; rb[n] = 10; rop[n] = 4'b0000;
            end else if (c == 6) begin
              pend[n] = 1; ra[n] = 10; rb[n] = 10;
              rop[n] = (n == 0) ? 4'b0001 : 4'b0000;
            end else if (c >= 13 && ((c >= 80 && c <= 140) || $urandom_range(3) != 0)) begin
              pend[n] = 1;
              ra[n]   = $urandom;
              rb[n]   = ($urandom_range(1) != 0) ? ra[n] : $urandom;
              rop[n]  = 4'($urandom);
            end
          end
          rdy[n] = (c < 13 || (c >= 80 && c <= 140)) ? 1'b1 : ($urandom_range(3) != 0);
        end
        if (c >= 40 && c <= 60) rdy[0] = 1'b0;
        bus.req0_valid = pend[0]; bus.req0_a = ra[0]; bus.req0_b = rb[0]; bus.req0_op = rop[0];
        bus.req1_valid = pend[1]; bus.req1_a = ra[1]; bus.req1_b = rb[1]; bus.req1_op = rop[1];
        bus.rsp0_ready = rdy[0];
        bus.rsp1_ready = rdy[1];

        @(negedge clk);
        if (rst_n) begin
          if (c == 2 || c == RSTC + 1) begin
            check($sformatf("L%0d c%0d reset_rsp", LAT, c),
                  128'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_data, bus.rsp1_zero,
                        bus.rsp1_overflow, bus.rsp0_data, bus.rsp0_zero, bus.rsp0_overflow}),
                  128'(0));
          end
          for (int n = 0; n < 2; n++) begin
            vexp[n] = ob[n] && (c >= ocyc[n]);
            hs[n]   = vexp[n] && rdy[n];
            el[n]   = pend[n] && (!ob[n] || hs[n]);
          end
          g[0] = el[0] && (!el[1] || lastg == 1);
          g[1] = el[1] && (!el[0] || lastg == 0);
          check($sformatf("L%0d c%0d req_ready", LAT, c),
                128'({bus.req1_ready, bus.req0_ready}), 128'({g[1], g[0]}));
          check($sformatf("L%0d c%0d rsp_valid", LAT, c),
                128'({bus.rsp1_valid, bus.rsp0_valid}), 128'({vexp[1], vexp[0]}));
          if (vexp[0])
            check($sformatf("L%0d c%0d rsp0", LAT, c),
                  128'({bus.rsp0_overflow, bus.rsp0_zero, bus.rsp0_data}), 128'(oexp[0]));
          if (vexp[1])
            check($sformatf("L%0d c%0d rsp1", LAT, c),
                  128'({bus.rsp1_overflow, bus.rsp1_zero, bus.rsp1_data}), 128'(oexp[1]));
          ea = '0; eb = '0; eop = 4'b0000;
          for (int n = 0; n < 2; n++) begin
            if (g[n]) begin ea = ra[n]; eb = rb[n]; eop = rop[n]; end
          end
          check($sformatf("L%0d c%0d alu_bus", LAT, c),
                128'({bus.alu_control, bus.alu_a, bus.alu_b}), 128'({eop, ea, eb}));
          for (int n = 0; n < 2; n++) begin
            if (hs[n]) ob[n] = 0;
            if (g[n]) begin
              ob[n]   = 1;
              oexp[n] = alu_f(ra[n], rb[n], rop[n]);
              ocyc[n] = c + LAT + 1;
              pend[n] = 0;
              lastg   = n;
            end
          end
        end
      end
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < NCYC + 20 && n_done < 3; i++) @(posedge clk);
    check("all_done", 128'(n_done), 128'(3));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
